// File: rtl/stream_seq_ctrl.sv
// Command sequencer for the DFX state-buffer streamer: one ordered reset/init pulse train and one status response per command.
// CLEAR responds 3 cycles after accept; one command in flight, cmd_ready stays low until the response handshake.
module stream_seq_ctrl #(
    parameter int STORAGE_IDX_WIDTH = 10,
    parameter int STATE_BIT_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES    = 65535,
    parameter int TIMEOUT_W         = 16,
    parameter int ABORT_CYCLES      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [1:0]                   rsp_code,
    output logic [STORAGE_IDX_WIDTH-1:0] rsp_words,
    output logic                         busy,
    output logic                         str_store_reset,
    output logic                         str_load_reset,
    output logic                         str_store_init,
    output logic                         str_load_init,
    input  logic                         str_fin_store,
    input  logic [STATE_BIT_WIDTH-1:0]   str_state,
    input  logic [STORAGE_IDX_WIDTH-1:0] str_store_cnt,
    output logic                         str_rst_n
);

    localparam int AB_W = $clog2(ABORT_CYCLES + 1);

    localparam logic [1:0] OP_STORE = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_EMPTY   = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;
    localparam logic [1:0] RSP_ILLEGAL = 2'd3;

    typedef enum logic [3:0] {
        IDLE, S_RST, S_INIT, S_WAIT, L_RST, L_INIT, L_WAIT, C_RST, ABORT, RESP
    } state_t;

    state_t                state, state_nxt;
    logic                  clr_seq, clr_seq_nxt;
    logic                  seen_load, seen_load_nxt;
    logic [TIMEOUT_W-1:0]  wdog, wdog_nxt;
    logic [AB_W-1:0]       abort_cnt, abort_cnt_nxt;
    logic [1:0]            code_nxt;
    logic                  wd_hit;

    assign wd_hit = (TIMEOUT_CYCLES != 0) && (wdog == TIMEOUT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            clr_seq   <= 1'b0;
            seen_load <= 1'b0;
            wdog      <= '0;
            abort_cnt <= '0;
            rsp_code  <= RSP_OK;
            rsp_words <= '0;
        end else begin
            state     <= state_nxt;
            clr_seq   <= clr_seq_nxt;
            seen_load <= seen_load_nxt;
            wdog      <= wdog_nxt;
            abort_cnt <= abort_cnt_nxt;
            // Response fields are frozen on RESP entry so they stay stable under backpressure.
            if (state_nxt == RESP && state != RESP) begin
                rsp_code  <= code_nxt;
                rsp_words <= str_store_cnt;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        clr_seq_nxt   = clr_seq;
        seen_load_nxt = seen_load;
        wdog_nxt      = wdog;
        abort_cnt_nxt = abort_cnt;
        code_nxt      = RSP_OK;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == RSP_ILLEGAL || str_state != '0) begin
                        state_nxt = RESP;
                        code_nxt  = RSP_ILLEGAL;
                    end else if (cmd_op == OP_LOAD && str_store_cnt == '0) begin
                        state_nxt = RESP;
                        code_nxt  = RSP_EMPTY;
                    end else if (cmd_op == OP_STORE) begin
                        state_nxt = S_RST;
                    end else if (cmd_op == OP_LOAD) begin
                        state_nxt   = L_RST;
                        clr_seq_nxt = 1'b0;
                    end else begin
                        state_nxt = C_RST;
                    end
                end
            end
            S_RST:  state_nxt = S_INIT;
            S_INIT: begin
                state_nxt = S_WAIT;
                wdog_nxt  = '0;
            end
            S_WAIT: begin
                if (str_fin_store) begin
                    state_nxt = RESP;
                    code_nxt  = RSP_OK;
                end else if (wd_hit) begin
                    state_nxt     = ABORT;
                    abort_cnt_nxt = '0;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            C_RST: begin
                state_nxt   = L_RST;
                clr_seq_nxt = 1'b1;
            end
            L_RST: begin
                seen_load_nxt = 1'b0;
                // The L_RST that follows C_RST finishes a CLEAR: no init pulse.
                if (clr_seq) begin
                    state_nxt   = RESP;
                    code_nxt    = RSP_OK;
                    clr_seq_nxt = 1'b0;
                end else begin
                    state_nxt = L_INIT;
                end
            end
            L_INIT: begin
                state_nxt = L_WAIT;
                wdog_nxt  = '0;
            end
            L_WAIT: begin
                if (str_state == STATE_BIT_WIDTH'(2)) seen_load_nxt = 1'b1;
                if (seen_load && str_state == '0) begin
                    state_nxt = RESP;
                    code_nxt  = RSP_OK;
                end else if (wd_hit) begin
                    state_nxt     = ABORT;
                    abort_cnt_nxt = '0;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            ABORT: begin
                if (abort_cnt == AB_W'(ABORT_CYCLES - 1)) begin
                    state_nxt = RESP;
                    code_nxt  = RSP_TIMEOUT;
                end else begin
                    abort_cnt_nxt = abort_cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign rsp_valid       = (state == RESP);
    assign str_store_reset = (state == S_RST) || (state == C_RST);
    assign str_store_init  = (state == S_INIT);
    assign str_load_reset  = (state == L_RST);
    assign str_load_init   = (state == L_INIT);
    assign str_rst_n       = reset & (state != ABORT);

endmodule

// File: doc/stream_seq_ctrl.md
Name: stream_seq_ctrl

Overview:
Command-driven sequencer for the DFX state-buffer streamer. It accepts single-word STORE / LOAD / CLEAR commands from the host-side control logic and emits the correctly ordered one-cycle reset/init pulses to the streamer. It monitors the streamer's completion and debug outputs, applies a watchdog timeout, and returns one status response per command. It sits between the sequencer control path and the streamer's control pins.

Parameters:
STORAGE_IDX_WIDTH, 10, width of streamer word counters.
STATE_BIT_WIDTH, 4, width of streamer state bus.
TIMEOUT_CYCLES, 65535, wait-state watchdog limit in cycles; 0 disables the watchdog.
TIMEOUT_W, 16, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_W.
ABORT_CYCLES, 2, number of cycles str_rst_n is held low on timeout (minimum 1).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=STORE, 1=LOAD, 2=CLEAR, 3=illegal
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_code  out  2  0=OK, 1=EMPTY, 2=TIMEOUT, 3=ILLEGAL
rsp_words  out  STORAGE_IDX_WIDTH  str_store_cnt captured at response
busy  out  1  high whenever state != IDLE
str_store_reset  out  1  one-cycle pulse to streamer storeReset
str_load_reset  out  1  one-cycle pulse to streamer loadReset
str_store_init  out  1  one-cycle pulse to streamer storeInit
str_load_init  out  1  one-cycle pulse to streamer loadInit
str_fin_store  in  1  streamer finStore (sticky until storeReset/loadReset)
str_state  in  STATE_BIT_WIDTH  streamer state; 0=IDLE, 1=STORE, 2=LOAD
str_store_cnt  in  STORAGE_IDX_WIDTH  streamer stored-word count
str_rst_n  out  1  streamer reset, active-low

Behaviour:
- States: IDLE, S_RST, S_INIT, S_WAIT, L_RST, L_INIT, L_WAIT, C_RST, ABORT, RESP.
- Reset values: state IDLE, all str_* pulses 0, rsp_valid 0, rsp_code 0, rsp_words 0, watchdog 0. str_rst_n = reset AND (state != ABORT), so the streamer is held in reset together with this block.
- Pulse outputs are decoded from the state register only, never from inputs:
  - store_reset in S_RST and C_RST.
  - store_init in S_INIT.
  - load_reset in L_RST and in the first cycle after C_RST.
  - load_init in L_INIT.
- CLEAR sequence: C_RST -> L_RST (load_reset asserted) -> RESP with code OK. No init pulse is issued.
- cmd_ready = (state == IDLE). On accept, checks are applied in priority order:
  1. op==3 or str_state != 0 -> RESP, code ILLEGAL.
  2. LOAD with str_store_cnt == 0 -> RESP, code EMPTY.
  3. Otherwise go to the first state of the op: STORE->S_RST, LOAD->L_RST, CLEAR->C_RST.
- Each RST and INIT state lasts exactly one cycle. Reset and init pulses are never simultaneous.
- S_WAIT:
  - Watchdog increments every cycle.
  - str_fin_store==1 -> RESP with OK. Response is visible one cycle after fin is first sampled high.
- L_WAIT:
  - A seen_load flag is set when str_state==2.
  - seen_load && str_state==0 -> RESP with OK.
  - seen_load is cleared on L_RST.
- Watchdog:
  - Cleared on entry to any WAIT state.
  - When it equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0) -> ABORT.
  - ABORT lasts ABORT_CYCLES cycles (own counter), then RESP with code TIMEOUT.
- RESP:
  - rsp_valid=1; rsp_code and rsp_words are registered on RESP entry and held stable until the handshake.
  - rsp_valid&rsp_ready -> IDLE. The earliest next cmd accept is the following cycle.
- No command is accepted while a response is pending or an operation is active.
- Async reset mid-operation: immediate return to reset values; any pending response is lost.
- Latency, STORE with streamer TLAST arriving at cycle k after accept: fin is seen in S_WAIT and rsp_valid rises the next cycle.
- Minimum CLEAR latency: accept -> rsp_valid = 3 cycles.

Test Plan:
1. STORE, streamer receives 5 beats with TLAST -> pulse order store_reset, store_init (one cycle each, consecutive); rsp_code=0, rsp_words=5.
2. LOAD after test 1 with rsp_ready held 0 for 4 cycles -> load_reset, load_init pulses; 5 beats streamed; rsp_valid held stable with code 0 until ready; cmd_ready=0 meanwhile.
3. LOAD after reset with str_store_cnt=0 -> no str_* pulses; rsp_code=1 one cycle after accept.
4. TIMEOUT_CYCLES=20, STORE with no TVALID -> str_rst_n low for exactly 2 cycles starting 20 cycles into S_WAIT, then rsp_code=2, rsp_words=0.
5. cmd_op=3, and separately STORE while str_state=1 -> rsp_code=3, no pulses.
6. Assert reset during L_WAIT -> busy=0, rsp_valid=0, str_rst_n=0 while reset is low; after release, CLEAR gives rsp_code=0 with rsp_valid 3 cycles after accept.
